// File: rtl/heartbeat_pulse_gen_if.sv
// RR-interval push channel into heartbeat_pulse_gen.
// Handshake: an entry transfers on a rising clock edge where rr_valid && rr_ready
// are both high. rr_ready depends only on registered queue state, never on
// rr_valid. If rr_valid is high while rr_ready is low, the entry is dropped and
// the master does not have to hold it.
interface heartbeat_pulse_gen_if;
  logic [11:0] rr_in;
  logic        rr_valid;
  logic        rr_ready;

  modport master (output rr_in, output rr_valid, input rr_ready);
  modport slave  (input rr_in, input rr_valid, output rr_ready);
endinterface

// File: rtl/heartbeat_pulse_gen.sv
// heartbeat_pulse_gen: synthetic heartbeat source.
// RR intervals (ms) are queued in a small FIFO. Each interval is replayed as a
// pulse train on the 1 kHz clock: the pulse is high for PULSE_W ticks, and
// successive rising edges are exactly one interval apart. When the queue runs
// dry the last interval repeats. Dropping enable lets the current period finish
// before the generator returns to idle.
// Optional build macro HB_JITTER_EN adds LFSR-driven jitter of -8..+7 ms to
// every interval popped from the queue.
module heartbeat_pulse_gen #(
  parameter int PULSE_W    = 20,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk_div,
  input  logic                         rst_n,
  input  logic                         enable,
  heartbeat_pulse_gen_if.slave         rr_bus,
  output logic                         pulse_out,
  output logic                         beat_start,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic [0:0]                   dbg_state
);

  localparam int              AW         = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]     FULL_CNT   = (AW+1)'(FIFO_DEPTH);
  localparam logic [11:0]     RR_MIN     = 12'(PULSE_W + 1);
  localparam logic [11:0]     HIGH_TICKS = 12'(PULSE_W);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Queue storage and state
  logic [11:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  // Generator state
  logic [0:0]    r_state;
  logic [11:0]   r_cnt;
  logic [11:0]   r_cur_rr;
  logic          r_pulse;
  logic          r_beat;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_period_end;
  logic [11:0]   w_head;
  logic [11:0]   w_load_rr;
  logic [11:0]   w_cnt_nx;

  assign w_full       = (r_count == FULL_CNT);
  assign w_empty      = (r_count == '0);
  assign w_push       = rr_bus.rr_valid && !w_full;
  assign w_head       = r_mem[r_rd_ptr];
  assign w_period_end = (r_state == ST_RUN) && (r_cnt == r_cur_rr - 12'd1);
  assign w_cnt_nx     = r_cnt + 12'd1;

  // Pop when starting from idle, or at the end of a period while still enabled.
  always_comb begin
    w_pop = 1'b0;
    if (enable && !w_empty) begin
      if (r_state == ST_IDLE) begin
        w_pop = 1'b1;
      end else if (w_period_end) begin
        w_pop = 1'b1;
      end
    end
  end

`ifdef HB_JITTER_EN
  logic [15:0] r_lfsr;
  logic        w_lfsr_fb;
  logic [13:0] w_sum;

  // Fibonacci taps 16,14,13,11 (bit indices 15,13,12,10).
  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  // Low nibble taken as a signed offset; 14 bits hold -8..4102 without overflow.
  assign w_sum     = {2'b00, w_head} + {{10{r_lfsr[3]}}, r_lfsr[3:0]};

  // Advance the LFSR once for every interval taken from the queue.
  always_ff @(posedge clk_div or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= 16'hACE1;
    end else if (w_pop) begin
      r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
    end
  end

  // Clamp the jittered interval to [PULSE_W+1, 4095].
  always_comb begin
    w_load_rr = w_sum[11:0];
    if (w_sum[13]) begin
      w_load_rr = RR_MIN;
    end else if (w_sum[12]) begin
      w_load_rr = 12'hFFF;
    end else if (w_sum[11:0] < RR_MIN) begin
      w_load_rr = RR_MIN;
    end
  end
`else
  // Intervals shorter than the pulse plus one low tick are stretched.
  assign w_load_rr = (w_head < RR_MIN) ? RR_MIN : w_head;
`endif

  // Queue data write; contents need no reset because the count gates reads.
  always_ff @(posedge clk_div) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= rr_bus.rr_in;
    end
  end

  // Queue pointers and occupancy; push and pop together leave the count alone.
  always_ff @(posedge clk_div or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Beat generator: period counter, registered pulse and beat strobe.
  always_ff @(posedge clk_div or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_cur_rr <= '0;
      r_pulse  <= 1'b0;
      r_beat   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_pulse <= 1'b0;
          r_beat  <= 1'b0;
          if (enable && !w_empty) begin
            r_state  <= ST_RUN;
            r_cur_rr <= w_load_rr;
            r_cnt    <= '0;
            r_pulse  <= 1'b1;
            r_beat   <= 1'b1;
          end
        end
        ST_RUN: begin
          r_beat <= 1'b0;
          if (w_period_end) begin
            r_cnt <= '0;
            if (enable) begin
              // Pulse is always low at period end, so this is a true rising edge.
              r_pulse <= 1'b1;
              r_beat  <= 1'b1;
              if (!w_empty) begin
                r_cur_rr <= w_load_rr;
              end
            end else begin
              r_state <= ST_IDLE;
              r_pulse <= 1'b0;
            end
          end else begin
            r_cnt   <= w_cnt_nx;
            r_pulse <= (w_cnt_nx < HIGH_TICKS);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_pulse <= 1'b0;
          r_beat  <= 1'b0;
        end
      endcase
    end
  end

  assign rr_bus.rr_ready = !w_full;
  assign pulse_out       = r_pulse;
  assign beat_start      = r_beat;
  assign busy            = (r_state == ST_RUN);
  assign fifo_count      = r_count;
  assign dbg_state       = r_state;

endmodule

// File: tb/tb_heartbeat_pulse_gen.sv
// Testbench for heartbeat_pulse_gen (default build, PULSE_W=20, FIFO_DEPTH=4).
// Reference model: a queue of expected intervals; each observed beat takes the
// next queued interval, or repeats the previous one if the queue is empty.
module tb_heartbeat_pulse_gen;
  localparam int PW     = 20;
  localparam int DEPTH  = 4;
  localparam int BUDGET = 6000;

  logic       clk_div = 1'b0;
  logic       rst_n   = 1'b0;
  logic       enable  = 1'b0;
  logic       pulse_out;
  logic       beat_start;
  logic       busy;
  logic [2:0] fifo_count;
  logic [0:0] dbg_state;

  heartbeat_pulse_gen_if rr_bus();

  heartbeat_pulse_gen #(.PULSE_W(PW), .FIFO_DEPTH(DEPTH)) dut (
    .clk_div    (clk_div),
    .rst_n      (rst_n),
    .enable     (enable),
    .rr_bus     (rr_bus),
    .pulse_out  (pulse_out),
    .beat_start (beat_start),
    .busy       (busy),
    .fifo_count (fifo_count),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_div = ~clk_div;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [11:0] exp_q[$];
  int          model_cur;
  logic [11:0] burst_v [8];

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // Interval the generator should use for a requested value.
  function automatic int exp_interval(input int v);
    return (v > PW + 1) ? v : PW + 1;
  endfunction

  // A new beat consumes the queue head, otherwise the previous interval repeats.
  function automatic void model_beat();
    if (exp_q.size() > 0) model_cur = exp_interval(int'(exp_q.pop_front()));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n           = 1'b0;
    enable          = 1'b0;
    rr_bus.rr_valid = 1'b0;
    rr_bus.rr_in    = '0;
    repeat (3) @(negedge clk_div);
    rst_n = 1'b1;
    @(negedge clk_div);
    exp_q.delete();
    model_cur = 0;
  endtask

  task automatic push(input logic [11:0] v);
    rr_bus.rr_in    = v;
    rr_bus.rr_valid = 1'b1;
    @(negedge clk_div);
    rr_bus.rr_valid = 1'b0;
  endtask

  // Pushes burst_v[0..n-1] back to back; reports the burst cycle of the first beat.
  task automatic burst_push(input int n, output int beat_cyc);
    beat_cyc = -1;
    for (int i = 0; i < n; i++) begin
      rr_bus.rr_in    = burst_v[i];
      rr_bus.rr_valid = 1'b1;
      @(negedge clk_div);
      if (beat_start && beat_cyc < 0) beat_cyc = i;
    end
    rr_bus.rr_valid = 1'b0;
  endtask

  task automatic wait_beat(output int waited);
    waited = 0;
    do begin
      @(negedge clk_div);
      waited++;
    end while (!beat_start && waited < BUDGET);
  endtask

  // Starting on a beat cycle, measures high time and distance to the next beat.
  task automatic measure(output int high, output int period, output bit rise_ok);
    logic prev;
    high   = 0;
    period = 0;
    prev   = 1'b1;
    do begin
      if (pulse_out) high++;
      prev = pulse_out;
      @(negedge clk_div);
      period++;
    end while (!beat_start && period < BUDGET);
    rise_ok = beat_start && !prev && pulse_out;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk_div);
    n_checks++; if (pulse_out !== 1'b0) begin n_fail++; $display("FAIL reset_pulse: got %b expected 0", pulse_out); end
    n_checks++; if (beat_start !== 1'b0) begin n_fail++; $display("FAIL reset_beat: got %b expected 0", beat_start); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
    n_checks++; if (rr_bus.rr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", rr_bus.rr_ready); end
    do_reset();
  endtask

  // Plays burst_v[0..n-1] with enable high and checks n_periods full periods.
  task automatic test_sequence(input string name, input int n, input int n_periods);
    int beat_cyc, waited, high, period;
    bit rise_ok;
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < n; i++) exp_q.push_back(burst_v[i]);
    burst_push(n, beat_cyc);
    model_beat();
    n_checks++; if (beat_cyc !== 1) begin n_fail++; $display("FAIL %s_latency: got %0d expected 1", name, beat_cyc); end
    n_checks++; if (fifo_count !== 3'(exp_q.size())) begin n_fail++; $display("FAIL %s_count: got %0d expected %0d", name, fifo_count, exp_q.size()); end
    wait_beat(waited);
    n_checks++; if (waited !== model_cur - n + 2) begin n_fail++; $display("FAIL %s_first_period: got %0d expected %0d", name, waited, model_cur - n + 2); end
    model_beat();
    for (int k = 0; k < n_periods; k++) begin
      measure(high, period, rise_ok);
      n_checks++; if (period !== model_cur) begin n_fail++; $display("FAIL %s_period%0d: got %0d expected %0d", name, k, period, model_cur); end
      n_checks++; if (high !== PW) begin n_fail++; $display("FAIL %s_high%0d: got %0d expected %0d", name, k, high, PW); end
      n_checks++; if (rise_ok !== 1'b1) begin n_fail++; $display("FAIL %s_rise%0d: got %b expected 1", name, k, rise_ok); end
      model_beat();
    end
  endtask

  task automatic test_fifo_full();
    int waited, high, period;
    bit rise_ok;
    do_reset();
    for (int i = 0; i < 4; i++) burst_v[i] = 12'($urandom_range(21, 150));
    burst_v[4] = 12'($urandom_range(200, 250));
    for (int i = 0; i < 5; i++) begin
      rr_bus.rr_in    = burst_v[i];
      rr_bus.rr_valid = 1'b1;
      @(negedge clk_div);
      if (exp_q.size() < DEPTH) exp_q.push_back(burst_v[i]);
      n_checks++; if (fifo_count !== 3'(exp_q.size())) begin n_fail++; $display("FAIL full_count%0d: got %0d expected %0d", i, fifo_count, exp_q.size()); end
      n_checks++; if (rr_bus.rr_ready !== (exp_q.size() < DEPTH)) begin n_fail++; $display("FAIL full_ready%0d: got %b expected %b", i, rr_bus.rr_ready, exp_q.size() < DEPTH); end
    end
    rr_bus.rr_valid = 1'b0;
    enable = 1'b1;
    wait_beat(waited);
    n_checks++; if (waited !== 1) begin n_fail++; $display("FAIL full_latency: got %0d expected 1", waited); end
    model_beat();
    for (int k = 0; k < 5; k++) begin
      measure(high, period, rise_ok);
      n_checks++; if (period !== model_cur) begin n_fail++; $display("FAIL full_period%0d: got %0d expected %0d", k, period, model_cur); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL full_busy%0d: got %b expected 1", k, busy); end
      model_beat();
    end
  endtask

  task automatic test_enable_drop();
    int waited, n;
    bit seen_beat, seen_pulse;
    do_reset();
    enable = 1'b1;
    push(12'd1000);
    wait_beat(waited);
    n_checks++; if (waited !== 1) begin n_fail++; $display("FAIL drop_latency: got %0d expected 1", waited); end
    repeat (300) @(negedge clk_div);
    enable    = 1'b0;
    n         = 0;
    seen_beat = 1'b0;
    do begin
      @(negedge clk_div);
      n++;
      if (beat_start) seen_beat = 1'b1;
    end while (busy && n < BUDGET);
    n_checks++; if (n !== 700) begin n_fail++; $display("FAIL drop_completion: got %0d cycles expected 700", n); end
    n_checks++; if (pulse_out !== 1'b0) begin n_fail++; $display("FAIL drop_pulse: got %b expected 0", pulse_out); end
    seen_pulse = 1'b0;
    repeat (50) begin
      @(negedge clk_div);
      if (beat_start) seen_beat = 1'b1;
      if (pulse_out) seen_pulse = 1'b1;
    end
    enable = 1'b1;
    repeat (20) begin
      @(negedge clk_div);
      if (beat_start) seen_beat = 1'b1;
      if (pulse_out || busy) seen_pulse = 1'b1;
    end
    n_checks++; if (seen_beat !== 1'b0) begin n_fail++; $display("FAIL drop_no_beat: got %b expected 0", seen_beat); end
    n_checks++; if (seen_pulse !== 1'b0) begin n_fail++; $display("FAIL drop_idle: got %b expected 0", seen_pulse); end
    push(12'd500);
    wait_beat(waited);
    n_checks++; if (waited !== 1) begin n_fail++; $display("FAIL drop_restart: got %0d expected 1", waited); end
  endtask

  task automatic test_reset_mid_pulse();
    int waited, high, period;
    bit rise_ok, seen;
    do_reset();
    enable = 1'b1;
    push(12'd800);
    wait_beat(waited);
    push(12'd400);
    repeat (4) @(negedge clk_div);
    n_checks++; if (pulse_out !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_pulse: got %b expected 1", pulse_out); end
    n_checks++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL rstmid_pre_count: got %0d expected 1", fifo_count); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (pulse_out !== 1'b0) begin n_fail++; $display("FAIL rstmid_pulse: got %b expected 0", pulse_out); end
    n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL rstmid_count: got %0d expected 0", fifo_count); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    @(negedge clk_div);
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (100) begin
      @(negedge clk_div);
      if (beat_start || pulse_out) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rstmid_quiet: got %b expected 0", seen); end
    push(12'd300);
    wait_beat(waited);
    n_checks++; if (waited !== 1) begin n_fail++; $display("FAIL rstmid_latency: got %0d expected 1", waited); end
    measure(high, period, rise_ok);
    n_checks++; if (period !== 300) begin n_fail++; $display("FAIL rstmid_period: got %0d expected 300", period); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rr_bus.rr_valid = 1'b0;
    rr_bus.rr_in    = '0;
    test_reset();

    burst_v[0] = 12'd800; burst_v[1] = 12'd800; burst_v[2] = 12'd800;
    test_sequence("steady", 3, 4);

    burst_v[0] = 12'd600; burst_v[1] = 12'd1000; burst_v[2] = 12'd400;
    test_sequence("pattern", 3, 4);

    burst_v[0] = 12'd0; burst_v[1] = 12'd15; burst_v[2] = 12'd21; burst_v[3] = 12'd22;
    test_sequence("clamp", 4, 5);

    test_fifo_full();
    test_enable_drop();
    test_reset_mid_pulse();

    for (int r = 0; r < 3; r++) begin
      int n;
      n = $urandom_range(2, 4);
      for (int i = 0; i < n; i++) burst_v[i] = 12'($urandom_range(0, 300));
      test_sequence("random", n, n + 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
